// File: rtl/arith_rr_sched.sv
// Round-robin scheduler sharing one registered add/multiply datapath between two requesters.
// Issues operands combinationally, delays the op select, and routes results back by in-flight tag.
module arith_rr_sched #(
    parameter int LAT     = 2,
    parameter int SEL_DLY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             hold,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_op,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic [31:0]      dp_a,
    output logic [31:0]      dp_b,
    output logic             dp_sel,
    input  logic [39:0]      dp_result,
    output logic             rsp0_valid,
    output logic [39:0]      rsp0_data,
    output logic             rsp1_valid,
    output logic [39:0]      rsp1_data,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1,
    output logic             idle
);

    // last_gnt = id of the most recently granted requester; 1 after reset so req0 wins the first tie
    logic               last_gnt;
    logic               gnt0, gnt1, issue, win_id, win_op;
    logic [LAT-1:0]     tag_v;
    logic [LAT-1:0]     tag_id;
    logic [SEL_DLY-1:0] sel_pipe;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!RST && !hold) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_gnt;
                gnt1 = ~last_gnt;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign issue      = gnt0 | gnt1;
    assign win_id     = gnt1;
    assign win_op     = gnt1 ? req1_op : req0_op;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        dp_a = '0;
        dp_b = '0;
        if (gnt0) begin
            dp_a = req0_a;
            dp_b = req0_b;
        end else if (gnt1) begin
            dp_a = req1_a;
            dp_b = req1_b;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            last_gnt <= 1'b1;
        end else if (issue) begin
            last_gnt <= win_id;
        end
    end

    // Tag pipeline mirrors the datapath latency; the last stage names the result's owner
    always_ff @(posedge clk) begin
        if (RST) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= issue;
            tag_id[0] <= issue ? win_id : 1'b0;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    // First stage holds between issues so dp_sel keeps its last value once it drains through
    always_ff @(posedge clk) begin
        if (RST) begin
            sel_pipe <= '0;
        end else begin
            sel_pipe[0] <= issue ? win_op : sel_pipe[0];
            for (int i = 1; i < SEL_DLY; i++) begin
                sel_pipe[i] <= sel_pipe[i-1];
            end
        end
    end

    assign dp_sel = sel_pipe[SEL_DLY-1];

    always_ff @(posedge clk) begin
        if (RST) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (gnt0 && (gnt_cnt0 != '1)) gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
            if (gnt1 && (gnt_cnt1 != '1)) gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
        end
    end

    assign rsp0_valid = tag_v[LAT-1] & ~tag_id[LAT-1];
    assign rsp1_valid = tag_v[LAT-1] &  tag_id[LAT-1];
    assign rsp0_data  = rsp0_valid ? dp_result : '0;
    assign rsp1_data  = rsp1_valid ? dp_result : '0;
    assign idle       = ~|tag_v;

endmodule

// File: tb/tb_arith_rr_sched.sv
// Bench for arith_rr_sched: directed plan sequences then random traffic, all checked each
// cycle against a queue-based reference model; a behavioural datapath closes the loop.
module tb_arith_rr_sched;

    localparam int LAT     = 2;
    localparam int SEL_DLY = 1;
    localparam int CNT_W   = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              clk;
    logic              RST;
    logic              hold;
    logic              req0_valid, req0_ready, req0_op;
    logic [31:0]       req0_a, req0_b;
    logic              req1_valid, req1_ready, req1_op;
    logic [31:0]       req1_a, req1_b;
    logic [31:0]       dp_a, dp_b;
    logic              dp_sel;
    logic [39:0]       dp_result;
    logic              rsp0_valid, rsp1_valid;
    logic [39:0]       rsp0_data, rsp1_data;
    logic [CNT_W-1:0]  gnt_cnt0, gnt_cnt1;
    logic              idle;

    arith_rr_sched #(.LAT(LAT), .SEL_DLY(SEL_DLY), .CNT_W(CNT_W)) dut (
        .clk(clk), .RST(RST), .hold(hold),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .dp_a(dp_a), .dp_b(dp_b), .dp_sel(dp_sel), .dp_result(dp_result),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .idle(idle)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural datapath: operands registered, select applied next cycle, result registered
    logic [31:0] dpa_r, dpb_r;
    always @(posedge clk) begin
        dpa_r     <= dp_a;
        dpb_r     <= dp_b;
        dp_result <= dp_sel ? 40'(33'(dpa_r) + 33'(dpb_r)) : 40'(64'(dpa_r) * 64'(dpb_r));
    end

    // reference model state
    typedef struct { int due; logic id; logic [39:0] data; } rsp_t;
    typedef struct { int eff; logic op; } sel_t;
    rsp_t             pend_q[$];
    sel_t             sel_q[$];
    logic             m_last;
    logic             m_sel;
    logic [CNT_W-1:0] m_cnt0, m_cnt1;
    int               cyc;
    int               checks, failures;

    function automatic logic [39:0] op_result(logic op, logic [31:0] a, logic [31:0] b);
        logic [63:0] prod;
        prod = 64'(a) * 64'(b);
        return op ? {7'd0, 33'(a) + 33'(b)} : prod[39:0];
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        pend_q.delete();
        sel_q.delete();
        m_last = 1'b1;
        m_sel  = 1'b0;
        m_cnt0 = '0;
        m_cnt1 = '0;
    endtask

    // scoreboard: compare every output this cycle, then advance the model past the next edge
    task automatic check_cycle();
        logic        e_g0, e_g1, e_v0, e_v1, e_id, e_op;
        logic [31:0] e_a, e_b;
        logic [39:0] e_d0, e_d1, e_res;
        rsp_t        r;
        e_g0 = 1'b0;
        e_g1 = 1'b0;
        if (!RST && !hold) begin
            if (req0_valid && req1_valid) begin
                if (m_last) e_g0 = 1'b1;
                else        e_g1 = 1'b1;
            end else if (req0_valid) begin
                e_g0 = 1'b1;
            end else if (req1_valid) begin
                e_g1 = 1'b1;
            end
        end
        e_a = e_g0 ? req0_a : (e_g1 ? req1_a : 32'd0);
        e_b = e_g0 ? req0_b : (e_g1 ? req1_b : 32'd0);
        while (sel_q.size() > 0 && sel_q[0].eff <= cyc) m_sel = sel_q.pop_front().op;

        check_eq("idle", idle, pend_q.size() == 0);
        e_v0 = 1'b0; e_v1 = 1'b0; e_d0 = '0; e_d1 = '0;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            r = pend_q.pop_front();
            if (r.id) begin e_v1 = 1'b1; e_d1 = r.data; end
            else      begin e_v0 = 1'b1; e_d0 = r.data; end
        end

        check_eq("req0_ready", req0_ready, e_g0);
        check_eq("req1_ready", req1_ready, e_g1);
        check_eq("dp_a", dp_a, e_a);
        check_eq("dp_b", dp_b, e_b);
        check_eq("dp_sel", dp_sel, m_sel);
        check_eq("rsp0_valid", rsp0_valid, e_v0);
        check_eq("rsp0_data", rsp0_data, e_d0);
        check_eq("rsp1_valid", rsp1_valid, e_v1);
        check_eq("rsp1_data", rsp1_data, e_d1);
        check_eq("gnt_cnt0", gnt_cnt0, m_cnt0);
        check_eq("gnt_cnt1", gnt_cnt1, m_cnt1);

        if (RST) begin
            model_reset();
        end else if (e_g0 || e_g1) begin
            e_id  = e_g1;
            e_op  = e_g1 ? req1_op : req0_op;
            e_res = op_result(e_op, e_a, e_b);
            m_last = e_id;
            if (!e_id && m_cnt0 != CNT_MAX) m_cnt0 = m_cnt0 + 1'b1;
            if (e_id && m_cnt1 != CNT_MAX) m_cnt1 = m_cnt1 + 1'b1;
            pend_q.push_back('{due: cyc + LAT, id: e_id, data: e_res});
            sel_q.push_back('{eff: cyc + SEL_DLY, op: e_op});
        end
        cyc++;
    endtask

    // driver: apply one cycle of inputs, check mid-cycle, move to just after the next edge
    task automatic drive(input logic rst, input logic hld,
                         input logic v0, input logic op0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic op1, input logic [31:0] a1, input logic [31:0] b1);
        RST = rst; hold = hld;
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_cycle();
        logic [31:0] a0, b0, a1, b1;
        a0 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        b0 = $urandom_range(0, 3) == 0 ? 32'(($urandom_range(0, 15))) : $urandom;
        a1 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        b1 = $urandom;
        drive($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) != 0, 1'($urandom), a0, b0,
              $urandom_range(0, 3) != 0, 1'($urandom), a1, b1);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        model_reset();
        RST = 1'b1; hold = 1'b0;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        repeat (3) @(posedge clk);
        #1;

        // single add, then single mul on requester 1
        drive(0, 0, 1, 1, 32'd5, 32'd7, 0, 0, 0, 0);
        quiet(4);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 32'd2);
        quiet(4);
        // fresh reset then contention for 4 cycles
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, i, 10, 1, 0, i + 3, 5);
        quiet(3);
        // back-to-back mixed ops from requester 0
        drive(0, 0, 1, 1, 32'd1, 32'd1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 32'd3, 32'd4, 0, 0, 0, 0);
        quiet(3);
        // in-flight op then hold with both valid, then release
        drive(0, 0, 0, 0, 0, 0, 1, 1, 32'd100, 32'd23);
        for (int i = 0; i < 3; i++) drive(0, 1, 1, 0, 32'd6, 32'd7, 1, 1, 32'd8, 32'd9);
        for (int i = 0; i < 2; i++) drive(0, 0, 1, 0, 32'd6, 32'd7, 1, 1, 32'd8, 32'd9);
        quiet(3);
        // reset one cycle after issue
        drive(0, 0, 1, 0, 32'd11, 32'd13, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        quiet(3);
        // long contention to drive both counters into saturation
        for (int i = 0; i < 150; i++) drive(0, 0, 1, 1'($urandom), $urandom, $urandom, 1, 1'($urandom), $urandom, $urandom);
        quiet(3);
        // random traffic
        for (int i = 0; i < 2000; i++) rand_cycle();
        quiet(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arith_rr_sched.md
Name: arith_rr_sched

Overview:
- Round-robin scheduler sharing one registered add/multiply datapath between two requesters.
- Datapath contract: registers operands, applies an unregistered add/mul select, then registers the 40-bit result.
- Block arbitrates requests, drives operands, delays the select to the cycle the datapath needs it, and tracks in-flight tags to route each result back to its requester.

Parameters:
- LAT, 2: cycles from issue handshake to result valid on dp_result; the tag pipeline is LAT deep.
- SEL_DLY, 1: cycles dp_sel lags dp_a/dp_b; must be less than LAT.
- CNT_W, 16: width of the per-requester grant counters.

Ports:
- clk  in  1  clock; one clock, all logic rising-edge.
- RST  in  1  reset; reset is synchronous and active-high.
- hold  in  1  1 = issue no new grants; in-flight operations still complete.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 granted this cycle (combinational).
- req0_op  in  1  1 = add, 0 = multiply.
- req0_a, req0_b  in  32 each  requester 0 operands.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0.
- dp_a, dp_b  out  32 each  operands to datapath (combinational, issue cycle).
- dp_sel  out  1  datapath select (1 = add result, 0 = mul result), registered.
- dp_result  in  40  datapath registered result.
- rsp0_valid  out  1  result for requester 0 this cycle.
- rsp0_data  out  40  result for requester 0.
- rsp1_valid, rsp1_data: same as requester 0.
- gnt_cnt0, gnt_cnt1  out  CNT_W each  saturating grant counters.
- idle  out  1  no operation in flight.

Behaviour:
- Reset (RST=1 at an edge):
  - Tag pipeline cleared; dp_sel=0; gnt_cnt0/1=0; last-grant pointer=1, so requester 0 wins the first tie.
  - Outputs next cycle: rsp*_valid=0, idle=1.
- Arbitration, combinational each cycle while RST=0 and hold=0:
  - Only one requester valid: grant it.
  - Both valid: grant the one not granted last.
  - Neither valid: no grant.
  - At most one of req0_ready/req1_ready is high per cycle.
  - Handshake = valid & ready; pointer updates only on a handshake.
- hold=1 or RST=1: both readys 0.
- Requester contract: keep valid and payload stable until ready. The block does not check this.
- Issue, handshake in cycle T:
  - dp_a/dp_b = winner's operands during cycle T; otherwise dp_a=dp_b=0.
  - dp_sel = winner's op, registered through SEL_DLY stages, so it is valid in cycle T+SEL_DLY.
  - Between issues dp_sel holds its last value.
- Tag pipeline:
  - LAT stages of {valid, id}; stage 0 is loaded on handshake ({1, winner}), else {0, x}.
  - Shifts every cycle.
  - Stage LAT-1 output in cycle T+LAT drives rsp<id>_valid=1 with rsp<id>_data=dp_result (pass-through).
  - Other rsp_valid=0; rsp_data of a non-valid port = 0.
- Throughput: one issue per cycle, fully pipelined; responses cannot be back-pressured and are never dropped except by reset.
- Order: results return in issue order, exactly LAT cycles after issue.
- Width: adds are 32+32 giving zero-extended 33 bits, muls are 64-bit truncated to 40 bits by the datapath. The block passes all 40 bits unmodified.
- gnt_cntN increments on each requester-N handshake and saturates at all-ones (no wrap).
- idle = no valid tag in any pipeline stage.
- Boundary cases:
  - hold asserted mid-stream: no new grants; pending tags still emit responses.
  - RST mid-operation: in-flight tags discarded, no response for them even if the datapath still produces data.
  - Requester drops valid while not granted: no effect on the pointer.

Test Plan:
- Single add: reset, req0 op=1 a=5 b=7 in cycle T -> req0_ready=1 at T, dp_sel=1 at T+1, rsp0_valid=1 with data 12 at T+2, idle=1 at T+3.
- Single mul: req1 op=0 a=0xFFFF_FFFF b=2 -> rsp1_data=0x01_FFFF_FFFE at T+2; rsp0_valid stays 0.
- Contention: both valid for 4 cycles after reset -> grants 0,1,0,1; responses alternate rsp0/rsp1 starting at T+2; gnt_cnt0=gnt_cnt1=2.
- Back-to-back mixed ops: req0 add 1+1 then mul 3*4 in consecutive cycles -> dp_sel 1 then 0 on consecutive cycles; rsp0 data 2 then 12.
- hold: assert hold with both valid for 3 cycles -> no readys, no new responses; an earlier in-flight op still responds at issue+2; on release, arbitration resumes with the correct pointer.
- Reset mid-flight: issue at T, RST=1 at T+1 -> no rsp at T+2, idle=1; gnt_cnt at 0xFFFF stays 0xFFFF on further grants (saturation, separate run).
